// File: rtl/shift_sequencer.sv
// Word serializer/deserializer with a divided bit clock, abort and optional even parity.
// Define SHIFT_SEQUENCER_PARITY_EN to append a parity bit period after the data bits.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             dir_i,
  input  logic             abort_i,
  output logic             sdo_o,
  input  logic             sdi_i,
  output logic             shift_stb_o,
  output logic             busy_o,
  output logic             rx_valid_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             parity_err_o
);

`ifdef SHIFT_SEQUENCER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_word, tx_next;
  logic [WIDTH-1:0] rx_shift, rx_next;
  logic             dir;
  logic             sdo;
  logic             accept, bit_end, last_bit;

  assign tx_next  = dir ? (tx_word >> 1) : (tx_word << 1);
  assign rx_next  = dir ? {sdi_i, rx_shift[WIDTH-1:1]} : {rx_shift[WIDTH-2:0], sdi_i};
  assign last_bit = (bit_cnt == BW'(NBITS - 1));
  assign sdo_o    = sdo;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    tx_ready_o  = 1'b0;
    busy_o      = 1'b0;
    rx_valid_o  = 1'b0;
    shift_stb_o = 1'b0;
    accept      = 1'b0;
    bit_end     = 1'b0;
    case (state)
      IDLE: begin
        tx_ready_o = 1'b1;
        accept     = tx_valid_i;
        if (tx_valid_i) state_next = SHIFT;
      end
      SHIFT: begin
        busy_o      = 1'b1;
        bit_end     = (div_cnt == CW'(DIV - 1));
        shift_stb_o = bit_end;
        // Abort beats completion even when it lands on the final strobe.
        if (abort_i)                   state_next = IDLE;
        else if (bit_end && last_bit)  state_next = DONE;
      end
      DONE: begin
        busy_o     = 1'b1;
        rx_valid_o = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SHIFT_SEQUENCER_PARITY_EN
  logic parity_bit;
  logic parity_err;
  assign parity_err_o = parity_err;
`else
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_word    <= '0;
      rx_shift   <= '0;
      rx_data_o  <= '0;
      dir        <= 1'b0;
      sdo        <= 1'b0;
`ifdef SHIFT_SEQUENCER_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else if (accept) begin
      tx_word    <= tx_data_i;
      dir        <= dir_i;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      sdo        <= dir_i ? tx_data_i[0] : tx_data_i[WIDTH-1];
`ifdef SHIFT_SEQUENCER_PARITY_EN
      parity_bit <= ^tx_data_i;
`endif
    end else if (state == SHIFT) begin
      if (abort_i) begin
        sdo     <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (!bit_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        bit_cnt <= bit_cnt + 1'b1;
        tx_word <= tx_next;
`ifdef SHIFT_SEQUENCER_PARITY_EN
        // The parity period samples sdi for comparison only; the word is already complete.
        if (last_bit) begin
          sdo        <= 1'b0;
          rx_data_o  <= rx_shift;
          parity_err <= sdi_i ^ (^rx_shift);
        end else begin
          rx_shift <= rx_next;
          if (bit_cnt == BW'(WIDTH - 1)) sdo <= parity_bit;
          else                           sdo <= dir ? tx_next[0] : tx_next[WIDTH-1];
        end
`else
        rx_shift <= rx_next;
        if (last_bit) begin
          sdo       <= 1'b0;
          rx_data_o <= rx_next;
        end else begin
          sdo <= dir ? tx_next[0] : tx_next[WIDTH-1];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed and randomized transfers against a bit-index reference model.
// A second instance with DIV=1 and sdo/sdi loopback covers back-to-back accepts.
module tb_shift_sequencer;
  localparam int WIDTH = 8;
  localparam int DIV   = 4;
`ifdef SHIFT_SEQUENCER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, tx_valid = 1'b0, dir = 1'b0, abort = 1'b0, sdi = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             tx_ready, sdo, stb, busy, rx_valid, perr;
  logic [WIDTH-1:0] rx_data;

  logic             tx_valid1 = 1'b0;
  logic [WIDTH-1:0] tx_data1 = '0;
  logic             tx_ready1, sdo1, stb1, busy1, rx_valid1, perr1;
  logic [WIDTH-1:0] rx_data1;

  logic [WIDTH-1:0] prev_rx = '0;
  logic             prev_err = 1'b0;
  int               n_cmp = 0;
  int               n_fail = 0;

  shift_sequencer #(.WIDTH(WIDTH), .DIV(DIV)) u_dut (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_data_i(tx_data), .dir_i(dir), .abort_i(abort), .sdo_o(sdo), .sdi_i(sdi),
    .shift_stb_o(stb), .busy_o(busy), .rx_valid_o(rx_valid), .rx_data_o(rx_data),
    .parity_err_o(perr)
  );

  shift_sequencer #(.WIDTH(WIDTH), .DIV(1)) u_div1 (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid1), .tx_ready_o(tx_ready1),
    .tx_data_i(tx_data1), .dir_i(1'b0), .abort_i(1'b0), .sdo_o(sdo1), .sdi_i(sdo1),
    .shift_stb_o(stb1), .busy_o(busy1), .rx_valid_o(rx_valid1), .rx_data_o(rx_data1),
    .parity_err_o(perr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkWord(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // k-th bit on the wire: data bits in the chosen order, then the even-parity bit.
  function automatic logic model_bit(input logic [WIDTH-1:0] w, input logic d, input int k);
    if (k >= WIDTH) return ^w;
    return d ? w[k] : w[WIDTH-1-k];
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, tx_ready, 1'b1);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_sdo"}, sdo, 1'b0);
    checkOutput({tag, "_stb"}, stb, 1'b0);
    checkOutput({tag, "_rxv"}, rx_valid, 1'b0);
    checkOutput({tag, "_perr"}, perr, 1'b0);
    checkWord({tag, "_rxd"}, rx_data, '0);
  endtask

  // mode 0: full transfer, 1: abort during cycle cut_at, 2: reset during cycle cut_at
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic d, input bit loop,
                               input bit bad_par, input int mode, input int cut_at);
    logic             rb [NB];
    logic [WIDTH-1:0] exp_rx;
    logic             exp_err;
    int               stb_seen;
    int               k;

    for (int i = 0; i < NB; i++)
      rb[i] = loop ? model_bit(word, d, i) : 1'($urandom_range(0, 1));
    if (bad_par && NB > WIDTH) rb[NB-1] = ~model_bit(word, d, NB - 1);
    exp_rx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d) exp_rx[i] = rb[i];
      else   exp_rx[WIDTH-1-i] = rb[i];
    end
    exp_err = (NB > WIDTH) ? (rb[NB-1] != ^exp_rx) : 1'b0;

    tx_data  = word;
    dir      = d;
    tx_valid = 1'b1;
    abort    = 1'b1;
    checkOutput("ready_idle", tx_ready, 1'b1);
    tick();
    // Keep offering a different word while busy; it must not disturb the transfer.
    tx_data  = ~word;
    dir      = ~d;
    abort    = 1'b0;
    stb_seen = 0;

    for (int c = 1; c <= NB * DIV; c++) begin
      k   = (c - 1) / DIV;
      sdi = rb[k];
      checkOutput("busy", busy, 1'b1);
      checkOutput("ready_busy", tx_ready, 1'b0);
      checkOutput("rxv_shift", rx_valid, 1'b0);
      checkOutput("sdo", sdo, model_bit(word, d, k));
      checkOutput("stb", stb, ((c - 1) % DIV) == DIV - 1);
      stb_seen += int'(stb);
      if (c == cut_at && mode == 1) abort = 1'b1;
      if (c == cut_at && mode == 2) begin
        rst   = 1'b1;
        abort = 1'b1;
      end
      tick();
      if (c == cut_at && mode == 1) begin
        abort    = 1'b0;
        tx_valid = 1'b0;
        checkOutput("abort_ready", tx_ready, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_rxv", rx_valid, 1'b0);
        checkOutput("abort_sdo", sdo, 1'b0);
        checkWord("abort_rxd", rx_data, prev_rx);
        checkOutput("abort_perr", perr, prev_err);
        tick();
        checkOutput("abort_idle_busy", busy, 1'b0);
        checkOutput("abort_idle_rxv", rx_valid, 1'b0);
        return;
      end
      if (c == cut_at && mode == 2) begin
        rst      = 1'b0;
        abort    = 1'b0;
        tx_valid = 1'b0;
        checkResetValues("midreset");
        tick();
        checkOutput("midreset_idle_busy", busy, 1'b0);
        prev_rx  = '0;
        prev_err = 1'b0;
        return;
      end
    end

    tx_valid = 1'b0;
    abort    = 1'b1;
    sdi      = 1'($urandom_range(0, 1));
    checkOutput("done_rxv", rx_valid, 1'b1);
    checkOutput("done_busy", busy, 1'b1);
    checkOutput("done_ready", tx_ready, 1'b0);
    checkOutput("done_sdo", sdo, 1'b0);
    checkOutput("done_stb", stb, 1'b0);
    checkWord("done_rxd", rx_data, exp_rx);
    checkOutput("done_perr", perr, exp_err);
    checkCount("stb_count", stb_seen, NB);
    tick();
    abort = 1'b0;
    checkOutput("post_ready", tx_ready, 1'b1);
    checkOutput("post_busy", busy, 1'b0);
    checkOutput("post_rxv", rx_valid, 1'b0);
    checkWord("post_rxd", rx_data, exp_rx);
    checkOutput("post_perr", perr, exp_err);
    prev_rx  = exp_rx;
    prev_err = exp_err;
  endtask

  // Back-to-back words with tx_valid held high: one accept per NB+2 cycles.
  task automatic runDiv1();
    logic [WIDTH-1:0] words [2];
    int               period, pos, j;
    words[0]  = 8'h81;
    words[1]  = 8'h42;
    period    = NB + 2;
    tx_data1  = words[0];
    tx_valid1 = 1'b1;
    checkOutput("d1_ready0", tx_ready1, 1'b1);
    tick();
    tx_data1 = words[1];
    for (int c = 1; c <= 2 * period; c++) begin
      pos = c % period;
      j   = c / period;
      checkOutput("d1_busy", busy1, pos != 0);
      checkOutput("d1_ready", tx_ready1, pos == 0);
      checkOutput("d1_stb", stb1, pos >= 1 && pos <= NB);
      checkOutput("d1_rxv", rx_valid1, pos == NB + 1);
      if (pos >= 1 && pos <= NB) checkOutput("d1_sdo", sdo1, model_bit(words[j], 1'b0, pos - 1));
      if (pos == NB + 1) begin
        checkWord("d1_rxd", rx_data1, words[j]);
        checkOutput("d1_perr", perr1, 1'b0);
      end
      if (c == period + 1) tx_valid1 = 1'b0;
      if (c < 2 * period) tick();
    end
  endtask

  initial begin
    // Reset overrides a pending word and abort.
    rst      = 1'b1;
    tx_valid = 1'b1;
    abort    = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tick();
    checkResetValues("reset");
    rst      = 1'b0;
    tx_valid = 1'b0;
    abort    = 1'b0;
    tick();
    checkOutput("reset_idle_busy", busy, 1'b0);

    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b0, 0, 0);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0, 1, 10);
    applyStimulus(8'h96, 1'b1, 1'b1, 1'b0, 1, NB * DIV);
    applyStimulus(8'hC3, 1'b0, 1'b1, 1'b0, 2, 15);
    applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus(8'h07, 1'b0, 1'b1, 1'b1, 0, 0);
    applyStimulus(8'h07, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus(WIDTH'($urandom), 1'($urandom_range(0, 1)), (i % 2) == 0, 1'b0, 0, 0);

    runDiv1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
